// File: rtl/ifddr_deser.sv
// DDR input capture and deserializer: samples one pad on both clock edges,
// re-times each rise/fall pair onto the rising edge and packs pairs into words.
module ifddr_deser #(
  parameter int DW = 8
) (
  input  logic          i_c,
  input  logic          i_clr,
  input  logic          i_ce,
  input  logic          i_d,
  input  logic          i_bitslip,
  output logic          o_q0,
  output logic          o_q1,
  output logic [DW-1:0] o_dout,
  output logic          o_valid
);

  localparam int PAIRS = DW / 2;
  localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  logic          r_rise;
  logic          r_fall;
  logic          r_q0;
  logic          r_q1;
  logic          r_v1;
  logic          r_v2;
  logic          r_lock;
  logic [CW-1:0] r_cnt;
  logic [DW-3:0] r_sr;
  logic [DW-1:0] r_dout;
  logic          r_valid;

  logic          w_slipAccept;
  logic          w_shift;
  logic          w_wordDone;
  logic [DW-1:0] w_srNext;

  // Falling-edge half of the capture; only has half a cycle to reach r_q1.
  always_ff @(negedge i_c or posedge i_clr) begin
    if (i_clr) begin
      r_fall <= 1'b0;
    end else if (i_ce) begin
      r_fall <= i_d;
    end
  end

  // A slip consumes the edge's shift slot, so it also wins over word completion.
  assign w_slipAccept = i_ce & r_v2 & i_bitslip & ~r_lock;
  assign w_shift      = i_ce & r_v2 & ~w_slipAccept;
  assign w_wordDone   = w_shift & (r_cnt == LAST);
  assign w_srNext     = {r_sr, r_q0, r_q1};

  always_ff @(posedge i_c or posedge i_clr) begin
    if (i_clr) begin
      r_rise  <= 1'b0;
      r_q0    <= 1'b0;
      r_q1    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (i_ce) begin
      r_rise  <= i_d;
      r_q0    <= r_rise;
      r_q1    <= r_fall;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
      r_valid <= w_wordDone;
      if (w_slipAccept) begin
        r_lock <= 1'b1;
      end else if (w_shift) begin
        r_sr <= w_srNext[DW-3:0];
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_dout <= w_srNext;
          r_lock <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_q0    = r_q0;
  assign o_q1    = r_q1;
  assign o_dout  = r_dout;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_ifddr_deser.sv
// Directed bench for ifddr_deser (DW=8 and DW=4 instances on shared inputs);
// expected words with their arrival step are queued and matched on VALID.
module tb_ifddr_deser;

  typedef struct {
    logic [7:0] word;
    int         step;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       ce;
  logic       d;
  logic       slip;

  logic       q0_8, q1_8, valid8;
  logic [7:0] dout8;
  logic       q0_4, q1_4, valid4;
  logic [3:0] dout4;

  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;
  int   s0;
  bit   mon8 = 1'b0;
  bit   mon4 = 1'b0;
  exp_t q8[$];
  exp_t q4[$];
  logic [63:0] stream;

  ifddr_deser #(.DW(8)) dut8 (
    .i_c(clk), .i_clr(clr), .i_ce(ce), .i_d(d), .i_bitslip(slip),
    .o_q0(q0_8), .o_q1(q1_8), .o_dout(dout8), .o_valid(valid8)
  );

  ifddr_deser #(.DW(4)) dut4 (
    .i_c(clk), .i_clr(clr), .i_ce(ce), .i_d(d), .i_bitslip(slip),
    .o_q0(q0_4), .o_q1(q1_4), .o_dout(dout4), .o_valid(valid4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Rise bit is set up before the posedge, fall bit before the following negedge.
  task automatic applyStimulus(input logic r, input logic f, input logic ceIn,
                               input logic slipIn);
    exp_t e;
    @(negedge clk);
    #1;
    d    = r;
    ce   = ceIn;
    slip = slipIn;
    @(posedge clk);
    #1;
    d    = f;
    slip = 1'b0;
    stepNo++;
    if (mon8 && ceIn) begin
      if (valid8) begin
        if (q8.size() == 0) begin
          checkOutput("unexpected_valid8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          checkOutput("dout8", dout8, e.word);
          checkOutput("valid8_step", stepNo, e.step);
        end
      end else if (q8.size() > 0 && q8[0].step == stepNo) begin
        checkOutput("missing_valid8", 32'd0, 32'd1);
        void'(q8.pop_front());
      end
    end
    if (mon4 && ceIn) begin
      if (valid4) begin
        if (q4.size() == 0) begin
          checkOutput("unexpected_valid4", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          checkOutput("dout4", dout4, e.word);
          checkOutput("valid4_step", stepNo, e.step);
        end
      end else if (q4.size() > 0 && q4[0].step == stepNo) begin
        checkOutput("missing_valid4", 32'd0, 32'd1);
        void'(q4.pop_front());
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    clr  = 1'b1;
    ce   = 1'b0;
    slip = 1'b0;
    d    = 1'b0;
    #1;
    clr  = 1'b0;
    q8.delete();
    q4.delete();
  endtask

  task automatic runStream(input logic [63:0] s, input int nSteps, input int slipA,
                           input int slipB, input int slipC, input bit checkQ);
    for (int j = 0; j < nSteps; j++) begin
      applyStimulus(s[63-2*j], s[62-2*j], 1'b1,
                    (j == slipA) || (j == slipB) || (j == slipC));
      if (checkQ && j > 0) begin
        checkOutput("q0_track", q0_8, s[65-2*j]);
        checkOutput("q1_track", q1_8, s[64-2*j]);
      end
    end
  endtask

  initial begin
    clr  = 1'b1;
    ce   = 1'b0;
    d    = 1'b0;
    slip = 1'b0;
    #3;
    checkOutput("rst_q0", q0_8, 1'b0);
    checkOutput("rst_q1", q1_8, 1'b0);
    checkOutput("rst_dout8", dout8, 8'h00);
    checkOutput("rst_valid8", valid8, 1'b0);
    checkOutput("rst_dout4", dout4, 4'h0);
    checkOutput("rst_valid4", valid4, 1'b0);
    #1;
    clr = 1'b0;

    // Plain stream, words every 4 cycles, Q0/Q1 one cycle behind the pad.
    doReset();
    mon8 = 1'b1;
    s0 = stepNo + 1;
    q8.push_back('{8'hA5, s0 + 5});
    q8.push_back('{8'h3C, s0 + 9});
    q8.push_back('{8'hFF, s0 + 13});
    q8.push_back('{8'h00, s0 + 17});
    runStream(64'hA53CFF00_00000000, 18, -1, -1, -1, 1'b1);
    checkOutput("main_drained", q8.size(), 0);

    // Three CE-low cycles right after the first word: VALID holds, later words slip by 3.
    doReset();
    stream = 64'hA53CFF00_00000000;
    s0 = stepNo + 1;
    q8.push_back('{8'hA5, s0 + 5});
    q8.push_back('{8'h3C, s0 + 12});
    q8.push_back('{8'hFF, s0 + 16});
    q8.push_back('{8'h00, s0 + 20});
    for (int j = 0; j < 18; j++) begin
      if (j == 6) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
          checkOutput("stall_valid_held", valid8, 1'b1);
          checkOutput("stall_dout_held", dout8, 8'hA5);
        end
      end
      applyStimulus(stream[63-2*j], stream[62-2*j], 1'b1, 1'b0);
    end
    checkOutput("stall_drained", q8.size(), 0);

    // 0x5A stream seen one pair late (0x69); three slips realign it.
    doReset();
    s0 = stepNo + 1;
    q8.push_back('{8'h69, s0 + 5});
    q8.push_back('{8'hA5, s0 + 10});
    q8.push_back('{8'h96, s0 + 15});
    q8.push_back('{8'h5A, s0 + 20});
    q8.push_back('{8'h5A, s0 + 24});
    runStream(64'h69696969_69696969, 25, 6, 11, 16, 1'b0);
    checkOutput("slip_drained", q8.size(), 0);
    checkOutput("slip_final_dout", dout8, 8'h5A);

    // Second slip while locked is ignored; slip on a word-complete edge suppresses it.
    doReset();
    s0 = stepNo + 1;
    q8.push_back('{8'hA5, s0 + 5});
    q8.push_back('{8'hF3, s0 + 10});
    q8.push_back('{8'h91, s0 + 15});
    q8.push_back('{8'hB0, s0 + 19});
    runStream(64'hA53CE41B_00000000, 20, 6, 8, 14, 1'b0);
    checkOutput("lock_drained", q8.size(), 0);

    // Three pairs into a new word, then an asynchronous clear between edges.
    runStream(64'hFC000000_00000000, 3, -1, -1, -1, 1'b0);
    checkOutput("preclr_dout", dout8, 8'hB0);
    checkOutput("preclr_q0", q0_8, 1'b1);
    #1;
    clr = 1'b1;
    #1;
    checkOutput("clr_q0", q0_8, 1'b0);
    checkOutput("clr_q1", q1_8, 1'b0);
    checkOutput("clr_dout", dout8, 8'h00);
    checkOutput("clr_valid", valid8, 1'b0);
    #1;
    clr = 1'b0;
    q8.delete();
    s0 = stepNo + 1;
    q8.push_back('{8'hA5, s0 + 5});
    q8.push_back('{8'h3C, s0 + 9});
    runStream(64'hA53C0000_00000000, 10, -1, -1, -1, 1'b0);
    checkOutput("postclr_drained", q8.size(), 0);

    // Narrow instance: word every 2 cycles, first after rise k+3.
    doReset();
    mon8 = 1'b0;
    mon4 = 1'b1;
    s0 = stepNo + 1;
    q4.push_back('{8'h09, s0 + 3});
    q4.push_back('{8'h06, s0 + 5});
    runStream(64'h96000000_00000000, 6, -1, -1, -1, 1'b0);
    checkOutput("dw4_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
